uart_mem_bridge: RTL and testbench
==================================

# uart_mem_bridge

Host-command responder on the far side of the byte interface of `uart_comm`. It pops received bytes and decodes host packets: write word, read word and ping. It performs single-word accesses on a simple memory request port and pushes response bytes back into the send FIFO. It sits between `uart_comm` and the memory/debug bus, so a host PC can load and inspect memory over the serial link.

## Interface
- `TIMEOUT_CYCLES`, default 800000: maximum idle gap, in cycles, between bytes of one packet before that packet is aborted.
- `CLK` input 1: clock.
- `RST` input 1: reset, asynchronous, active-high.
- `receivable` input 1: receive FIFO non-empty.
- `recv_data` input 8: head byte of the receive FIFO; valid while `receivable`=1.
- `recv_flag` output 1: one-cycle pop of the receive FIFO.
- `sendable` input 1: send FIFO not full.
- `send_flag` output 1: one-cycle push to the send FIFO.
- `send_data` output 8: byte pushed with `send_flag`.
- `mem_req` output 1: memory request, held until accepted.
- `mem_we` output 1: 1 = write, 0 = read.
- `mem_addr` output 32: word address.
- `mem_wdata` output 32: write data.
- `mem_rdata` input 32: read data, valid in the `mem_ready` cycle.
- `mem_ready` input 1: request accepted/completed this cycle.
- `busy` output 1: high in any state other than CMD.

## Operation
- Packets. All multi-byte fields are little-endian.
  - Ping: 0x03. Response is 0x5A.
  - Write: 0x01, addr[4], data[4]. Response is 0xA5 after the memory completes.
  - Read: 0x02, addr[4]. Response is rdata[4].
  - Any other opcode: response 0xEE, then return to CMD.
- FSM states: CMD, ADDR, DATA, CSUM, MEM, RESP.
  - CMD, on a valid opcode: ping → RESP; read/write → ADDR; invalid → RESP with 0xEE.
  - ADDR collects 4 bytes, then goes to DATA (write), CSUM (with checksum enabled) or MEM.
  - DATA collects 4 bytes, then goes to CSUM or MEM.
  - MEM holds `mem_req` until `mem_ready`, then goes to RESP.
  - RESP emits 1 or 4 bytes, then returns to CMD.
- Byte intake:
  - A byte is taken when `receivable`=1 in a byte-collecting state and no pop was issued in the previous cycle.
  - `recv_flag` pulses for exactly one cycle per byte.
  - Pops are never back-to-back, so FIFO status can settle.
- Byte output:
  - A byte is pushed when `sendable`=1 and no push was issued in the previous cycle.
  - `send_flag` is never high in consecutive cycles.
  - If `sendable`=0, RESP stalls indefinitely; no byte is dropped.
- Field assembly: byte k (0..3) is written into field bits [8k+7:8k].
- Timeout:
  - A counter clears on every accepted byte and counts in ADDR, DATA and CSUM.
  - When it reaches `TIMEOUT_CYCLES`-1, the FSM returns to CMD with no memory access and no response.
  - It does not count in CMD, MEM or RESP.
- Reads capture `mem_rdata` in the `mem_ready` cycle. `mem_addr`, `mem_wdata` and `mem_we` stay stable while `mem_req`=1.
- Reset values: state CMD, all counters 0. Every output is 0: `recv_flag`, `send_flag`, `send_data`, `mem_req`, `mem_we`, `mem_addr`, `mem_wdata`, `busy`.
- Reset mid-packet or mid-access: the transaction is abandoned immediately and `mem_req` drops. Bytes already pushed stay in the FIFO.

## Timing
- `recv_flag`, `send_flag`, `send_data` and the `mem_*` outputs are registered.
- Pop `recv_flag` is asserted the cycle after `receivable` is sampled high; the byte is latched in that same sampling edge.
- Fastest packet intake is 1 byte per 2 cycles.
- `mem_req` rises 1 cycle after the last byte (or the checksum) is latched.
- `mem_ready` high in the same cycle as `mem_req` rise completes the access; `mem_req` is low on the next edge.
- First response byte is pushed 1 cycle after MEM exit at the earliest. Read responses are 4 pushes spaced at least 2 cycles apart.
- Ping latency: 0x5A is pushed 2 cycles after the opcode pop at the earliest.
- `busy` updates on the same edge as the state.

## Configuration
- `UART_BRIDGE_CHECKSUM_EN`
  - Defined: every packet except ping carries a trailing byte equal to the XOR of all preceding packet bytes, opcode included. On a mismatch the bridge responds 0xEE and performs no memory access. The timeout applies while waiting for the checksum.
  - Undefined: the CSUM state and checksum register are absent, and packets end at their last data field.

## Structure
- Shared package `uart_bridge_pkg`:
  - opcode constants: `OP_WRITE`=0x01, `OP_READ`=0x02, `OP_PING`=0x03
  - response constants: `RSP_ACK`=0xA5, `RSP_PONG`=0x5A, `RSP_ERR`=0xEE
  - FSM state encoding
- Sub-module `uart_bridge_rsp_ser`: response serializer.
  - Loads a 32-bit word and a byte count of 1 or 4.
  - Emits bytes LSB first under the `sendable` / no-consecutive-push rule.
  - Reports done.

## Test plan
- Ping: push 0x03 → exactly one `send_flag` with 0x5A; no `mem_req`.
- Write: 01 10 00 00 00 EF BE AD DE → `mem_req` with `mem_we`=1, addr 0x00000010, wdata 0xDEADBEEF. With `mem_ready` 3 cycles late → response 0xA5 only after ready.
- Read: 02 10 00 00 00, `mem_rdata`=0x12345678 → pushes 78 56 34 12. Hold `sendable`=0 for 20 cycles mid-response → no loss, order kept.
- Invalid opcode 0x7F → 0xEE, then a following ping still yields 0x5A.
- Timeout with `TIMEOUT_CYCLES`=50: send 02 10 00, wait 60 cycles → back in CMD, `busy`=0, no response. Then a ping → 0x5A.
- With `UART_BRIDGE_CHECKSUM_EN`: write packet with checksum 0x00 (wrong) → 0xEE, no `mem_req`. Correct checksum → 0xA5. Also assert `RST` during MEM → `mem_req`=0 immediately.

Source files
------------

// File: rtl/uart_bridge_pkg.sv
// uart_bridge_pkg: shared constants and types for the UART-to-memory bridge.
// Holds the host opcodes, the response bytes and the bridge FSM state encoding.
// Build option UART_BRIDGE_CHECKSUM_EN adds the CSUM state.
package uart_bridge_pkg;

  localparam logic [7:0] OP_WRITE = 8'h01;
  localparam logic [7:0] OP_READ  = 8'h02;
  localparam logic [7:0] OP_PING  = 8'h03;

  localparam logic [7:0] RSP_ACK  = 8'hA5;
  localparam logic [7:0] RSP_PONG = 8'h5A;
  localparam logic [7:0] RSP_ERR  = 8'hEE;

  // Explicit encodings keep the state values identical whether or not CSUM exists.
  typedef enum logic [2:0] {
    ST_CMD  = 3'd0,
    ST_ADDR = 3'd1,
    ST_DATA = 3'd2,
`ifdef UART_BRIDGE_CHECKSUM_EN
    ST_CSUM = 3'd3,
`endif
    ST_MEM  = 3'd4,
    ST_RESP = 3'd5
  } state_t;

endpackage

// File: rtl/uart_mem_bridge_if.sv
// uart_mem_bridge_if: byte-FIFO and memory-request signals of the bridge.
//   receivable/recv_data/recv_flag : receive FIFO status, head byte, pop
//   sendable/send_flag/send_data   : send FIFO status, push, pushed byte
//   mem_req/mem_we/mem_addr/mem_wdata/mem_rdata/mem_ready : single-word access port
// master = the bridge, slave = the FIFOs/memory side.
interface uart_mem_bridge_if;
  logic        receivable;
  logic [7:0]  recv_data;
  logic        recv_flag;
  logic        sendable;
  logic        send_flag;
  logic [7:0]  send_data;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ready;

  modport master (
    input  receivable, recv_data, sendable, mem_rdata, mem_ready,
    output recv_flag, send_flag, send_data, mem_req, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    output receivable, recv_data, sendable, mem_rdata, mem_ready,
    input  recv_flag, send_flag, send_data, mem_req, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/uart_bridge_rsp_ser.sv
// uart_bridge_rsp_ser: response serializer for the bridge.
//   CLK, RST       : clock, asynchronous active-high reset
//   load           : capture load_word and byte count (load_four ? 4 : 1)
//   sendable       : send FIFO not full
//   send_flag/data : registered one-cycle push, never in consecutive cycles
//   done           : no bytes left to emit
// Bytes leave LSB first.
module uart_bridge_rsp_ser (
  input  logic        CLK,
  input  logic        RST,
  input  logic        load,
  input  logic [31:0] load_word,
  input  logic        load_four,
  input  logic        sendable,
  output logic        send_flag,
  output logic [7:0]  send_data,
  output logic        done
);

  logic [31:0] shreg;
  logic [2:0]  remain;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      shreg     <= '0;
      remain    <= '0;
      send_flag <= 1'b0;
      send_data <= '0;
    end else begin
      send_flag <= 1'b0;
      if (load) begin
        shreg  <= load_word;
        remain <= load_four ? 3'd4 : 3'd1;
      end else if ((remain != '0) && sendable && !send_flag) begin
        send_flag <= 1'b1;
        send_data <= shreg[7:0];
        shreg     <= {8'h00, shreg[31:8]};
        remain    <= remain - 3'd1;
      end
    end
  end

  assign done = (remain == '0);

endmodule

// File: rtl/uart_mem_bridge.sv
// uart_mem_bridge: decodes host packets popped from the UART receive FIFO
// (ping 0x03, write 0x01 addr[4] data[4], read 0x02 addr[4], little-endian),
// performs one memory word access and pushes the response into the send FIFO.
//   CLK, RST : clock, asynchronous active-high reset
//   bus      : uart_mem_bridge_if.master (FIFO byte ports + memory request port)
//   busy     : high whenever the FSM is not in CMD
// Parameter TIMEOUT_CYCLES: idle gap between packet bytes before abort.
// Build option UART_BRIDGE_CHECKSUM_EN: trailing XOR checksum byte on
// write/read packets; mismatch answers 0xEE without a memory access.
module uart_mem_bridge
  import uart_bridge_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 800000
) (
  input  logic             CLK,
  input  logic             RST,
  uart_mem_bridge_if.master bus,
  output logic             busy
);

  localparam logic [31:0] TMO_LAST = 32'(TIMEOUT_CYCLES - 1);
`ifdef UART_BRIDGE_CHECKSUM_EN
  localparam state_t ST_FIELDS_DONE = ST_CSUM;
`else
  localparam state_t ST_FIELDS_DONE = ST_MEM;
`endif

  state_t      state, state_nx;
  logic [1:0]  byte_cnt;
  logic [31:0] tmo_cnt;
  logic [31:0] rsp_word;
  logic        rsp_four;
  logic        rsp_armed;
  logic        collecting, counting, take, tmo_hit;
  logic        mem_done, mem_req_d, ser_load, ser_done;
  logic        ser_flag;
  logic [7:0]  ser_data;
`ifdef UART_BRIDGE_CHECKSUM_EN
  logic [7:0]  csum;
`endif

  // State register
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= ST_CMD;
    else     state <= state_nx;
  end

  // Output / strobe decode
  always_comb begin
    collecting = (state == ST_CMD) || (state == ST_ADDR) || (state == ST_DATA);
    counting   = (state == ST_ADDR) || (state == ST_DATA);
`ifdef UART_BRIDGE_CHECKSUM_EN
    collecting = collecting || (state == ST_CSUM);
    counting   = counting || (state == ST_CSUM);
`endif
    // A pop in the previous cycle blocks intake so the FIFO status can settle.
    take      = collecting && bus.receivable && !bus.recv_flag;
    tmo_hit   = counting && !take && (tmo_cnt == TMO_LAST);
    mem_done  = (state == ST_MEM) && bus.mem_req && bus.mem_ready;
    mem_req_d = (state == ST_MEM) && !mem_done;
    // Serializer is loaded in the first RESP cycle, after rsp_word has settled.
    ser_load  = (state == ST_RESP) && !rsp_armed;
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      ST_CMD: begin
        if (take) begin
          if ((bus.recv_data == OP_READ) || (bus.recv_data == OP_WRITE)) state_nx = ST_ADDR;
          else                                                           state_nx = ST_RESP;
        end
      end
      ST_ADDR: begin
        if (tmo_hit)                          state_nx = ST_CMD;
        else if (take && (byte_cnt == 2'd3))  state_nx = bus.mem_we ? ST_DATA : ST_FIELDS_DONE;
      end
      ST_DATA: begin
        if (tmo_hit)                          state_nx = ST_CMD;
        else if (take && (byte_cnt == 2'd3))  state_nx = ST_FIELDS_DONE;
      end
`ifdef UART_BRIDGE_CHECKSUM_EN
      ST_CSUM: begin
        if (tmo_hit)   state_nx = ST_CMD;
        else if (take) state_nx = (bus.recv_data == csum) ? ST_MEM : ST_RESP;
      end
`endif
      ST_MEM:  if (mem_done) state_nx = ST_RESP;
      ST_RESP: if (rsp_armed && ser_done) state_nx = ST_CMD;
      default: state_nx = ST_CMD;
    endcase
  end

  // Registered outputs and datapath
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      bus.recv_flag <= 1'b0;
      bus.mem_req   <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
      byte_cnt      <= '0;
      tmo_cnt       <= '0;
      rsp_word      <= '0;
      rsp_four      <= 1'b0;
      rsp_armed     <= 1'b0;
`ifdef UART_BRIDGE_CHECKSUM_EN
      csum          <= '0;
`endif
    end else begin
      bus.recv_flag <= take;
      bus.mem_req   <= mem_req_d;
      rsp_armed     <= (state == ST_RESP);
      tmo_cnt       <= (counting && !take) ? tmo_cnt + 32'd1 : '0;

      if ((state == ST_ADDR) || (state == ST_DATA)) begin
        if (take) byte_cnt <= byte_cnt + 2'd1;
      end else begin
        byte_cnt <= '0;
      end

      case (state)
        ST_CMD: begin
          if (take) begin
`ifdef UART_BRIDGE_CHECKSUM_EN
            csum <= bus.recv_data;
`endif
            rsp_four <= 1'b0;
            rsp_word <= {24'h0, (bus.recv_data == OP_PING) ? RSP_PONG : RSP_ERR};
            if ((bus.recv_data == OP_READ) || (bus.recv_data == OP_WRITE))
              bus.mem_we <= (bus.recv_data == OP_WRITE);
          end
        end
        ST_ADDR: begin
          if (take) begin
            bus.mem_addr[{byte_cnt, 3'b000} +: 8] <= bus.recv_data;
`ifdef UART_BRIDGE_CHECKSUM_EN
            csum <= csum ^ bus.recv_data;
`endif
          end
        end
        ST_DATA: begin
          if (take) begin
            bus.mem_wdata[{byte_cnt, 3'b000} +: 8] <= bus.recv_data;
`ifdef UART_BRIDGE_CHECKSUM_EN
            csum <= csum ^ bus.recv_data;
`endif
          end
        end
`ifdef UART_BRIDGE_CHECKSUM_EN
        ST_CSUM: begin
          if (take && (bus.recv_data != csum)) begin
            rsp_word <= {24'h0, RSP_ERR};
            rsp_four <= 1'b0;
          end
        end
`endif
        ST_MEM: begin
          if (mem_done) begin
            rsp_word <= bus.mem_we ? {24'h0, RSP_ACK} : bus.mem_rdata;
            rsp_four <= !bus.mem_we;
          end
        end
        default: ;
      endcase
    end
  end

  uart_bridge_rsp_ser u_rsp_ser (
    .CLK       (CLK),
    .RST       (RST),
    .load      (ser_load),
    .load_word (rsp_word),
    .load_four (rsp_four),
    .sendable  (bus.sendable),
    .send_flag (ser_flag),
    .send_data (ser_data),
    .done      (ser_done)
  );

  assign bus.send_flag = ser_flag;
  assign bus.send_data = ser_data;
  assign busy          = (state != ST_CMD);

endmodule

// File: tb/tb_uart_mem_bridge.sv
// tb_uart_mem_bridge: directed self-checking bench for uart_mem_bridge
// (TIMEOUT_CYCLES = 50). Honours UART_BRIDGE_CHECKSUM_EN when defined.
module tb_uart_mem_bridge;

  logic CLK = 1'b0;
  logic RST;
  logic busy;

  uart_mem_bridge_if bif ();

  uart_mem_bridge #(.TIMEOUT_CYCLES(50)) dut (
    .CLK  (CLK),
    .RST  (RST),
    .bus  (bif),
    .busy (busy)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Bus monitor, sampled on the falling edge
  logic [7:0]  rsp_q[$];
  int          cyc = 0, pop_cyc = 0, push_cyc = 0, req_cyc = 0, req_rises = 0, viol = 0;
  logic        prev_send = 1'b0, prev_recv = 1'b0, prev_req = 1'b0, req_we = 1'b0;
  logic [31:0] req_addr = '0, req_wdata = '0;

  always @(negedge CLK) begin
    cyc++;
    if (bif.recv_flag) pop_cyc = cyc;
    if (bif.send_flag) begin
      rsp_q.push_back(bif.send_data);
      push_cyc = cyc;
    end
    if (bif.send_flag && prev_send) viol++;
    if (bif.recv_flag && prev_recv) viol++;
    if (bif.mem_req && !prev_req) begin
      req_rises++;
      req_cyc   = cyc;
      req_addr  = bif.mem_addr;
      req_wdata = bif.mem_wdata;
      req_we    = bif.mem_we;
    end else if (bif.mem_req && prev_req &&
                 ((bif.mem_addr != req_addr) || (bif.mem_wdata != req_wdata) || (bif.mem_we != req_we))) begin
      viol++;
    end
    prev_send = bif.send_flag;
    prev_recv = bif.recv_flag;
    prev_req  = bif.mem_req;
  end

  task automatic tick();
    @(negedge CLK);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    bit got;
    got = 1'b0;
    tick();
    bif.receivable = 1'b1;
    bif.recv_data  = b;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (bif.recv_flag) begin
        got = 1'b1;
        break;
      end
    end
    bif.receivable = 1'b0;
    check("pop", {31'h0, got}, 32'd1);
  endtask

  task automatic send_pkt(input logic [7:0] b [9], input int n, input bit add_csum);
    logic [7:0] x;
    x = 8'h00;
    for (int i = 0; i < n; i++) begin
      send_byte(b[i]);
      x = x ^ b[i];
    end
`ifdef UART_BRIDGE_CHECKSUM_EN
    if (add_csum) send_byte(x);
`else
    if (add_csum) x = 8'h00;
`endif
  endtask

  task automatic wait_rsp(input int n, input int budget);
    for (int i = 0; i < budget; i++) begin
      if (rsp_q.size() >= n) break;
      tick();
    end
  endtask

  task automatic wait_req(input string tag);
    for (int i = 0; i < 30; i++) begin
      if (bif.mem_req) break;
      tick();
    end
    check(tag, {31'h0, bif.mem_req}, 32'd1);
  endtask

  task automatic mem_ack(input logic [31:0] rdata);
    bif.mem_rdata = rdata;
    bif.mem_ready = 1'b1;
    tick();
    bif.mem_ready = 1'b0;
    bif.mem_rdata = '0;
  endtask

  task automatic do_ping(input string tag);
    int rises;
    rises = req_rises;
    rsp_q.delete();
    send_byte(8'h03);
    wait_rsp(1, 20);
    repeat (4) tick();
    check({tag, "_cnt"}, rsp_q.size(), 1);
    if (rsp_q.size() > 0) check({tag, "_byte"}, {24'h0, rsp_q[0]}, 32'h5A);
    check({tag, "_lat"}, {31'h0, (push_cyc - pop_cyc) >= 2}, 32'd1);
    check({tag, "_noreq"}, req_rises, rises);
    check({tag, "_idle"}, {31'h0, busy}, 32'd0);
  endtask

  logic [7:0] pkt [9];
  int         rises0;
  logic [7:0] exp_rd [4];

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    RST            = 1'b1;
    bif.receivable = 1'b0;
    bif.recv_data  = '0;
    bif.sendable   = 1'b1;
    bif.mem_rdata  = '0;
    bif.mem_ready  = 1'b0;
    repeat (3) tick();

    // Reset state
    check("rst_recv_flag", {31'h0, bif.recv_flag}, 0);
    check("rst_send_flag", {31'h0, bif.send_flag}, 0);
    check("rst_send_data", {24'h0, bif.send_data}, 0);
    check("rst_mem_req",   {31'h0, bif.mem_req}, 0);
    check("rst_mem_we",    {31'h0, bif.mem_we}, 0);
    check("rst_mem_addr",  bif.mem_addr, 0);
    check("rst_mem_wdata", bif.mem_wdata, 0);
    check("rst_busy",      {31'h0, busy}, 0);
    RST = 1'b0;
    repeat (2) tick();

    // Ping
    do_ping("ping");

    // Write with memory ready 3 cycles late
    rsp_q.delete();
    pkt = '{8'h01, 8'h10, 8'h00, 8'h00, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    send_pkt(pkt, 9, 1'b1);
    wait_req("wr_req");
    check("wr_req_lat", req_cyc - pop_cyc, 1);
    check("wr_we",      {31'h0, req_we}, 1);
    check("wr_addr",    req_addr, 32'h0000_0010);
    check("wr_wdata",   req_wdata, 32'hDEAD_BEEF);
    repeat (3) tick();
    check("wr_hold_req", {31'h0, bif.mem_req}, 1);
    check("wr_no_early_rsp", rsp_q.size(), 0);
    mem_ack('0);
    check("wr_req_drop", {31'h0, bif.mem_req}, 0);
    wait_rsp(1, 20);
    repeat (4) tick();
    check("wr_rsp_cnt", rsp_q.size(), 1);
    if (rsp_q.size() > 0) check("wr_rsp", {24'h0, rsp_q[0]}, 32'hA5);

    // Read with a 20-cycle sendable stall after the first byte
    rsp_q.delete();
    pkt = '{8'h02, 8'h10, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    send_pkt(pkt, 5, 1'b1);
    wait_req("rd_req");
    check("rd_we",   {31'h0, req_we}, 0);
    check("rd_addr", req_addr, 32'h0000_0010);
    mem_ack(32'h1234_5678);
    wait_rsp(1, 20);
    bif.sendable = 1'b0;
    repeat (20) tick();
    check("rd_stall_cnt", rsp_q.size(), 1);
    bif.sendable = 1'b1;
    wait_rsp(4, 40);
    repeat (4) tick();
    check("rd_rsp_cnt", rsp_q.size(), 4);
    exp_rd = '{8'h78, 8'h56, 8'h34, 8'h12};
    for (int i = 0; i < 4; i++)
      if (rsp_q.size() > i) check($sformatf("rd_byte%0d", i), {24'h0, rsp_q[i]}, {24'h0, exp_rd[i]});

    // Invalid opcode, then ping
    rsp_q.delete();
    rises0 = req_rises;
    send_byte(8'h7F);
    wait_rsp(1, 20);
    repeat (4) tick();
    check("inv_cnt", rsp_q.size(), 1);
    if (rsp_q.size() > 0) check("inv_rsp", {24'h0, rsp_q[0]}, 32'hEE);
    check("inv_noreq", req_rises, rises0);
    do_ping("inv_ping");

    // Timeout mid-address
    rsp_q.delete();
    rises0 = req_rises;
    pkt = '{8'h02, 8'h10, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    send_pkt(pkt, 3, 1'b0);
    check("tmo_busy_before", {31'h0, busy}, 1);
    repeat (60) tick();
    check("tmo_busy_after", {31'h0, busy}, 0);
    check("tmo_no_rsp", rsp_q.size(), 0);
    check("tmo_noreq", req_rises, rises0);
    do_ping("tmo_ping");

`ifdef UART_BRIDGE_CHECKSUM_EN
    // Wrong checksum (true XOR is 0x33)
    rsp_q.delete();
    rises0 = req_rises;
    pkt = '{8'h01, 8'h10, 8'h00, 8'h00, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    send_pkt(pkt, 9, 1'b0);
    send_byte(8'h00);
    wait_rsp(1, 20);
    repeat (4) tick();
    check("cs_bad_cnt", rsp_q.size(), 1);
    if (rsp_q.size() > 0) check("cs_bad_rsp", {24'h0, rsp_q[0]}, 32'hEE);
    check("cs_bad_noreq", req_rises, rises0);

    // Correct checksum
    rsp_q.delete();
    send_pkt(pkt, 9, 1'b1);
    wait_req("cs_ok_req");
    mem_ack('0);
    wait_rsp(1, 20);
    repeat (4) tick();
    check("cs_ok_cnt", rsp_q.size(), 1);
    if (rsp_q.size() > 0) check("cs_ok_rsp", {24'h0, rsp_q[0]}, 32'hA5);
`endif

    // Reset during MEM
    pkt = '{8'h02, 8'h20, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    send_pkt(pkt, 5, 1'b1);
    wait_req("rst_mem_req_seen");
    @(negedge CLK);
    RST = 1'b1;
    #1;
    check("rst_mem_req_drop", {31'h0, bif.mem_req}, 0);
    check("rst_mem_busy",     {31'h0, busy}, 0);
    tick();
    RST = 1'b0;
    repeat (2) tick();
    do_ping("post_rst_ping");

    check("protocol_viol", viol, 0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
